// File: rtl/instruction_encoder.sv
// RV32 instruction-word encoder that streams encoded words into instruction memory.
// Optional macro ENC_RANGE_CHECK_EN rejects immediates that do not fit their format.
module instruction_encoder (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    input  logic        start_i,
    input  logic [31:0] base_addr_i,
    output logic        mem_we_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [15:0] count_o,
    output logic        err_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] next_addr;
    logic [15:0] count;
    logic        err;
    // Set when a start_i reloaded the counters while a write was still stalled.
    logic        stale;

    logic        accept;
    logic        complete;
    logic        fmt_legal;
    logic        imm_ok;
    logic        legal;
    logic [31:0] word;
    logic [31:0] cur_next;

    assign complete    = mem_we && mem_ready_i;
    assign req_ready_o = !mem_we || mem_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign fmt_legal   = (fmt_i <= 3'd5);

    always_comb begin
        word = 32'd0;
        case (fmt_i)
            FMT_R: word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            FMT_I: word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            FMT_S: word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            FMT_B: word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], opcode_i};
            FMT_U: word = {imm_i[31:12], rd_i, opcode_i};
            FMT_J: word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            default: word = 32'd0;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // Signed fit: every bit above the sign bit must replicate it.
    always_comb begin
        imm_ok = 1'b1;
        case (fmt_i)
            FMT_I, FMT_S: imm_ok = (imm_i[31:11] == {21{imm_i[11]}});
            FMT_B:        imm_ok = (imm_i[31:12] == {20{imm_i[12]}}) && !imm_i[0];
            FMT_J:        imm_ok = (imm_i[31:20] == {12{imm_i[20]}}) && !imm_i[0];
            FMT_U:        imm_ok = (imm_i[11:0] == 12'd0);
            default:      imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign legal = fmt_legal && imm_ok;

    // A write retiring in this same cycle has already advanced the address it hands over.
    assign cur_next = (complete && !stale) ? next_addr + 32'd4 : next_addr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (accept) begin
            mem_we <= legal;
            if (legal) begin
                mem_addr  <= start_i ? base_addr_i : cur_next;
                mem_wdata <= word;
            end
        end else if (complete) begin
            mem_we <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            next_addr <= 32'd0;
            count     <= 16'd0;
            stale     <= 1'b0;
        end else if (start_i) begin
            next_addr <= base_addr_i;
            count     <= 16'd0;
            stale     <= mem_we && !mem_ready_i;
        end else if (complete) begin
            if (!stale) begin
                next_addr <= next_addr + 32'd4;
                count     <= count + 16'd1;
            end
            stale <= 1'b0;
        end
    end

    // A rejected request in the same cycle as start_i still leaves the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err <= 1'b0;
        end else begin
            err <= (err && !start_i) || (accept && !legal);
        end
    end

    assign mem_we_o    = mem_we;
    assign busy_o      = mem_we;
    assign mem_addr_o  = mem_addr;
    assign mem_wdata_o = mem_wdata;
    assign count_o     = count;
    assign err_o       = err;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed scoreboard bench for instruction_encoder; adapts the 0x800 immediate
// case to whether ENC_RANGE_CHECK_EN is defined.
module tb_instruction_encoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  fmt_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [31:0] imm_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic        mem_we_o;
    logic        mem_ready_i;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [15:0] count_o;
    logic        err_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int writes_seen = 0;
    logic [63:0] exp_q[$];

    instruction_encoder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .start_i(start_i), .base_addr_i(base_addr_i),
        .mem_we_o(mem_we_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .count_o(count_o), .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: a write retires at the next rising edge whenever we and ready are both high here.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && mem_we_o === 1'b1 && mem_ready_i === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none",
                         mem_addr_o, mem_wdata_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                checkOutput("write_addr", mem_addr_o, e[63:32]);
                checkOutput("write_data", mem_wdata_o, e[31:0]);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] fmt, input logic [6:0] op,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm,
                                 input logic exp_write, input logic [31:0] exp_addr,
                                 input logic [31:0] exp_word);
        bit done;
        done = 0;
        fmt_i = fmt; opcode_i = op; funct3_i = f3; funct7_i = f7;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        req_valid_i = 1'b1;
        if (exp_write) exp_q.push_back({exp_addr, exp_word});
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk_i);
            if (req_ready_o) done = 1;
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
        end
    endtask

    task automatic startPulse(input logic [31:0] base);
        start_i = 1'b1;
        base_addr_i = base;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        int w0;
        logic [31:0] held_addr, held_data;
        rst_i = 1'b1; req_valid_i = 1'b0; start_i = 1'b0; base_addr_i = 32'd0;
        mem_ready_i = 1'b1; fmt_i = 3'd0; opcode_i = 7'd0; funct3_i = 3'd0;
        funct7_i = 7'd0; rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0; imm_i = 32'd0;
        #1;
        checkOutput("rst_ready", {31'd0, req_ready_o}, 32'd1);
        checkOutput("rst_we", {31'd0, mem_we_o}, 32'd0);
        checkOutput("rst_count", {16'd0, count_o}, 32'd0);
        checkOutput("rst_err", {31'd0, err_o}, 32'd0);
        checkOutput("rst_addr", mem_addr_o, 32'd0);
        checkOutput("rst_data", mem_wdata_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Basic I-type after start.
        startPulse(32'h100);
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h100, 32'h00500093);
        idleCycles(3);
        checkOutput("count_after_first", {16'd0, count_o}, 32'd1);

        // Back-to-back stream with memory always ready.
        applyStimulus(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h104, 32'h002081B3);
        applyStimulus(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1, 32'h108, 32'h0020A423);
        applyStimulus(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1, 32'h10C, 32'hFE208EE3);
        applyStimulus(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 1, 32'h110, 32'h008000EF);
        applyStimulus(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1, 32'h114, 32'h123452B7);
        idleCycles(3);
        checkOutput("count_after_stream", {16'd0, count_o}, 32'd6);

        // Stall for three cycles.
        mem_ready_i = 1'b0;
        w0 = writes_seen;
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd1, 5'd0, 32'd1, 1, 32'h118, 32'h00108113);
        held_addr = mem_addr_o;
        held_data = mem_wdata_o;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("stall_we", {31'd0, mem_we_o}, 32'd1);
            checkOutput("stall_ready", {31'd0, req_ready_o}, 32'd0);
            checkOutput("stall_addr", mem_addr_o, held_addr);
            checkOutput("stall_data", mem_wdata_o, held_data);
        end
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b1;
        idleCycles(3);
        checkOutput("stall_one_write", writes_seen - w0, 32'd1);
        checkOutput("count_after_stall", {16'd0, count_o}, 32'd7);

        // Out-of-range I immediate.
        w0 = writes_seen;
`ifdef ENC_RANGE_CHECK_EN
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 0, 32'd0, 32'd0);
        idleCycles(3);
        checkOutput("range_err", {31'd0, err_o}, 32'd1);
        checkOutput("range_no_write", writes_seen - w0, 32'd0);
        checkOutput("range_count", {16'd0, count_o}, 32'd7);
`else
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 1, 32'h11C, 32'h80000093);
        idleCycles(3);
        checkOutput("trunc_err", {31'd0, err_o}, 32'd0);
        checkOutput("trunc_write", writes_seen - w0, 32'd1);
        checkOutput("trunc_count", {16'd0, count_o}, 32'd8);
`endif

        // Illegal format after a fresh start.
        startPulse(32'h200);
        checkOutput("start_err_clr", {31'd0, err_o}, 32'd0);
        checkOutput("start_count_clr", {16'd0, count_o}, 32'd0);
        w0 = writes_seen;
        applyStimulus(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 32'd0, 32'd0);
        idleCycles(3);
        checkOutput("illegal_err", {31'd0, err_o}, 32'd1);
        checkOutput("illegal_no_write", writes_seen - w0, 32'd0);
        checkOutput("illegal_count", {16'd0, count_o}, 32'd0);

        // start_i while a write is stalled: write keeps its address but is not counted.
        mem_ready_i = 1'b0;
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h200, 32'h00500093);
        startPulse(32'h300);
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b1;
        idleCycles(3);
        checkOutput("stale_count", {16'd0, count_o}, 32'd0);
        checkOutput("stale_err_clr", {31'd0, err_o}, 32'd0);
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 32'h300, 32'h00500093);
        idleCycles(3);
        checkOutput("reload_count", {16'd0, count_o}, 32'd1);

        // Reset during a stall drops the pending write without a clock edge.
        mem_ready_i = 1'b0;
        applyStimulus(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 32'd0, 32'd0);
        @(negedge clk_i);
        checkOutput("pre_rst_we", {31'd0, mem_we_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("async_rst_we", {31'd0, mem_we_o}, 32'd0);
        checkOutput("async_rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("async_rst_addr", mem_addr_o, 32'd0);
        checkOutput("async_rst_data", mem_wdata_o, 32'd0);
        checkOutput("async_rst_count", {16'd0, count_o}, 32'd0);
        checkOutput("async_rst_ready", {31'd0, req_ready_o}, 32'd1);
        w0 = writes_seen;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        idleCycles(4);
        checkOutput("post_rst_no_write", writes_seen - w0, 32'd0);
        checkOutput("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The module SHALL expose these ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  encode request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high at a rising edge.
- fmt_i  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 illegal.
- opcode_i  in  7  opcode field.
- funct3_i  in  3  funct3 field.
- funct7_i  in  7  funct7 field.
- rd_i  in  5  destination register.
- rs1_i  in  5  source register 1.
- rs2_i  in  5  source register 2.
- imm_i  in  32  immediate, full-width value.
- start_i  in  1  loads base_addr_i into the address counter; clears count_o and err_o.
- base_addr_i  in  32  program base byte address.
- mem_we_o  out  1  instruction-memory write valid.
- mem_ready_i  in  1  memory accepts the write when mem_we_o and mem_ready_i are both high.
- mem_addr_o  out  32  write byte address.
- mem_wdata_o  out  32  encoded instruction word.
- count_o  out  16  words written since the last start_i.
- err_o  out  1  sticky error flag.
- busy_o  out  1  equals mem_we_o.

Function
REQ-002 Encoding SHALL place fields by format:
- R: {funct7, rs2, rs1, funct3, rd, opcode}
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- U: {imm[31:12], rd, opcode}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
REQ-003 One output register stage SHALL be used: a request accepted at edge N drives mem_we_o=1 with the stable word and address from edge N onward, until the write completes.
REQ-004 req_ready_o SHALL equal (!mem_we_o || mem_ready_i), giving one word per cycle when memory is always ready.
REQ-005 While mem_we_o=1 and mem_ready_i=0, mem_addr_o and mem_wdata_o SHALL hold stable.
REQ-006 On write completion the internal next-address SHALL increment by 4 (32-bit wrap from 0xFFFFFFFC to 0), and count_o SHALL increment by 1 (wrap from 0xFFFF to 0).
REQ-007 mem_addr_o SHALL be captured from the next-address counter at acceptance. If start_i coincides with acceptance, the request SHALL use base_addr_i and next-address SHALL become base_addr_i+4 on completion.
REQ-008 start_i during a pending write SHALL NOT alter that write's address or data. The completing write SHALL NOT be counted after the clear, and SHALL NOT advance the reloaded counter.
REQ-009 An illegal fmt_i (6 or 7) SHALL be accepted, SHALL NOT generate a write, and SHALL set err_o.
REQ-010 err_o SHALL remain set until start_i or reset.

Reset
REQ-011 When rst_i is asserted, the following SHALL be forced low or zero immediately (asynchronously) and any pending write SHALL be dropped: mem_we_o, busy_o, err_o, count_o, mem_addr_o, mem_wdata_o and next-address.
REQ-012 req_ready_o SHALL read 1 during and after reset.

Configuration
REQ-013 With ENC_RANGE_CHECK_EN defined, these immediate checks SHALL apply; a violating request SHALL be accepted, dropped without a write, and SHALL set err_o:
- I/S: imm_i must fit signed 12 bits.
- B: imm_i must fit signed 13 bits with imm[0]=0.
- J: imm_i must fit signed 21 bits with imm[0]=0.
- U: imm_i[11:0] must be 0.
REQ-014 Without ENC_RANGE_CHECK_EN, immediates SHALL be truncated silently per REQ-002, and only REQ-009 SHALL set err_o.

Verification
REQ-015 start_i with base 0x100, then I op=0x13 rd=1 rs1=0 imm=5 -> write 0x00500093 at 0x100; count_o=1.
REQ-016 Back-to-back with mem_ready_i=1:
- R op=0x33 rd=3 rs1=1 rs2=2 -> 0x002081B3.
- S op=0x23 f3=2 rs1=1 rs2=2 imm=8 -> 0x0020A423.
- Addresses increment by 4 each cycle.
REQ-017 Control-flow and upper-immediate encodings:
- B op=0x63 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
- J op=0x6F rd=1 imm=8 -> 0x008000EF.
- U op=0x37 rd=5 imm=0x12345000 -> 0x123452B7.
REQ-018 mem_ready_i low for 3 cycles -> mem_we_o, address and data held stable, req_ready_o=0; exactly one write completes.
REQ-019 I op=0x13 rd=1 imm=0x800:
- With macro: no write, err_o=1, count_o unchanged.
- Without macro: 0x80000093 written.
- fmt_i=7: err_o=1, no write.
REQ-020 rst_i asserted mid-stall -> mem_we_o=0 with no clock edge required; no write completes after release.
